// File: rtl/key_press_gen_pkg.sv
// Shared constants for the key injection path and the switch debouncers.
// Holds the FSM state encoding, default hold/gap lengths in swtick periods,
// the debounce window length, and a helper that sizes the tick counter.
package key_press_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRESS = 2'b01,
    ST_GAP   = 2'b10
  } kp_state_e;

  localparam int DEF_HOLD_TICKS  = 4;
  localparam int DEF_GAP_TICKS   = 4;
  localparam int DEF_CODE_W      = 6;
  localparam int DEBOUNCE_WINDOW = 3;

  // Width able to hold max(a, b); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_press_gen_tick_counter.sv
// Counts swtick strobes with a synchronous clear.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous active-high reset
//   clr_i   - synchronous clear, dominates counting
//   tick_i  - count enable strobe
//   last_i  - terminal value minus one; reloadable every cycle
//   term_o  - high in the cycle whose tick reaches the terminal count
// The counter returns to zero on the terminal tick, so it never wraps.
module key_press_gen_tick_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Combinational so the owning FSM can change state on the same edge.
  assign term_o = tick_i & ~clr_i & (count_q == last_i);

  always_comb begin
    count_d = count_q;
    if (clr_i || term_o) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/key_press_gen.sv
// Scripted key injection: turns a one-shot request into a clean, timed
// key-down level that a downstream switch debouncer accepts exactly once.
// Ports:
//   swclock        - system clock
//   reset          - synchronous active-high reset
//   swtick         - debounce timebase strobe
//   req / code     - press request and key code, taken only in IDLE
//   busy           - high during PRESS and GAP
//   done           - one-cycle pulse when the release gap completes
//   key_active     - registered key-down level
//   key_active_neg - inverted level for pull-up matrix lines
//   key_code       - code of the last accepted press
//   state          - current FSM state (debug)
//
// state | meaning
// IDLE  | waiting for req; key released
// PRESS | key held down for HOLD_TICKS ticks
// GAP   | key released for GAP_TICKS ticks before the next press
module key_press_gen
  import key_press_gen_pkg::*;
#(
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int CODE_W     = DEF_CODE_W
) (
  input  logic              swclock,
  input  logic              reset,
  input  logic              swtick,
  input  logic              req,
  input  logic [CODE_W-1:0] code,
  output logic              busy,
  output logic              done,
  output logic              key_active,
  output logic              key_active_neg,
  output logic [CODE_W-1:0] key_code,
  output logic [1:0]        state
);

  localparam int               CNT_W     = cnt_width(HOLD_TICKS, GAP_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  kp_state_e         state_q;
  logic              busy_q;
  logic              done_q;
  logic              key_active_q;
  logic [CODE_W-1:0] key_code_q;

  logic             cnt_clr;
  logic             cnt_term;
  logic [CNT_W-1:0] cnt_last;

  // Held clear outside PRESS/GAP, so a tick in the accepting cycle is not counted.
  assign cnt_clr  = (state_q != ST_PRESS) && (state_q != ST_GAP);
  assign cnt_last = (state_q == ST_GAP) ? GAP_LAST : HOLD_LAST;

  key_press_gen_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk_i  (swclock),
    .rst_i  (reset),
    .clr_i  (cnt_clr),
    .tick_i (swtick),
    .last_i (cnt_last),
    .term_o (cnt_term)
  );

  always_ff @(posedge swclock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      key_active_q <= 1'b0;
      key_code_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q       <= 1'b0;
          key_active_q <= 1'b0;
          if (req) begin
            key_code_q   <= code;
            key_active_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (cnt_term) begin
            key_active_q <= 1'b0;
            state_q      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_term) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          key_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign key_active     = key_active_q;
  assign key_active_neg = ~key_active_q;
  assign key_code       = key_code_q;
  assign state          = state_q;

endmodule

// File: tb/tb_key_press_gen.sv
module tb_key_press_gen;

  localparam int HOLD = 4;
  localparam int GAP  = 4;

  logic       swclock;
  logic       reset;
  logic       swtick;
  logic       req;
  logic [5:0] code;
  logic       busy;
  logic       done;
  logic       key_active;
  logic       key_active_neg;
  logic [5:0] key_code;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  bit tick_always = 1'b0;
  int tick_div    = 0;

  key_press_gen #(
    .HOLD_TICKS (HOLD),
    .GAP_TICKS  (GAP),
    .CODE_W     (6)
  ) dut (
    .swclock        (swclock),
    .reset          (reset),
    .swtick         (swtick),
    .req            (req),
    .code           (code),
    .busy           (busy),
    .done           (done),
    .key_active     (key_active),
    .key_active_neg (key_active_neg),
    .key_code       (key_code),
    .state          (state)
  );

  initial begin
    swclock = 1'b0;
    forever #5 swclock = ~swclock;
  end

  // swtick changes only on the falling edge, so it is stable at every rising edge.
  initial begin
    swtick = 1'b0;
    forever begin
      @(negedge swclock);
      tick_div = (tick_div == 9) ? 0 : tick_div + 1;
      swtick   = tick_always || (tick_div == 9);
    end
  end

  // Reference 3-tick switch debouncer fed by key_active.
  logic [2:0] db_hist;
  logic       dbsw, dbsw_prev;
  int         db_rises = 0;
  int         db_falls = 0;

  always @(posedge swclock) begin
    if (reset) begin
      db_hist   <= 3'b000;
      dbsw      <= 1'b0;
      dbsw_prev <= 1'b0;
    end else begin
      dbsw_prev <= dbsw;
      if (dbsw && !dbsw_prev) db_rises <= db_rises + 1;
      if (!dbsw && dbsw_prev) db_falls <= db_falls + 1;
      if (swtick) begin
        db_hist <= {db_hist[1:0], key_active};
        if ({db_hist[1:0], key_active} == 3'b111) dbsw <= 1'b1;
        else if ({db_hist[1:0], key_active} == 3'b000) dbsw <= 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_edge(output logic tk);
    @(posedge swclock);
    tk = swtick;
    #1;
  endtask

  // Follows one press from the cycle after acceptance up to the done pulse.
  // Flags 'bad' on any busy/done/key_code/key_active inconsistency on the way.
  task automatic measure(input bit noise, output int hold_t, output int hold_cyc,
                         output int gap_t, output int gap_cyc, output bit bad,
                         output bit tmo);
    logic       tk;
    logic [5:0] code0;
    int         n;
    code0 = key_code;
    hold_t = 0; hold_cyc = 0; gap_t = 0; gap_cyc = 0; bad = 0; tmo = 0; n = 0;
    while (key_active === 1'b1 && n < 500) begin
      if (noise) begin
        req  = 1'($urandom_range(0, 1));
        code = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00;
      end
      wait_edge(tk);
      n++; hold_cyc++;
      if (tk) hold_t++;
      if (busy !== 1'b1 || done !== 1'b0 || key_code !== code0) bad = 1;
    end
    if (n >= 500) tmo = 1;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      if (noise) begin
        if (gap_t < GAP - 1) begin
          req  = 1'($urandom_range(0, 1));
          code = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00;
        end else begin
          req = 1'b0;
        end
      end
      wait_edge(tk);
      n++; gap_cyc++;
      if (tk) gap_t++;
      if (key_active !== 1'b0 || key_code !== code0) bad = 1;
      if (done !== 1'b1 && busy !== 1'b1) bad = 1;
    end
    if (n >= 500) tmo = 1;
  endtask

  task automatic test_reset();
    logic tk;
    reset = 1'b1; req = 1'b0; code = 6'h00;
    repeat (3) wait_edge(tk);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %0h exp 0", state); end
    n_checks++; if (key_active !== 1'b0) begin n_fail++; $display("FAIL reset_key_active: got %b exp 0", key_active); end
    n_checks++; if (key_active_neg !== 1'b1) begin n_fail++; $display("FAIL reset_key_active_neg: got %b exp 1", key_active_neg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_checks++; if (key_code !== 6'h00) begin n_fail++; $display("FAIL reset_key_code: got %0h exp 0", key_code); end
    reset = 1'b0;
    repeat (2) wait_edge(tk);
  endtask

  task automatic test_single_press();
    logic tk;
    int ht, hc, gt, gc;
    bit bad, tmo;
    req = 1'b1; code = 6'h15;
    wait_edge(tk);
    req = 1'b0; code = 6'h00;
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL single_key_up: got %b exp 1", key_active); end
    n_checks++; if (key_active_neg !== 1'b0) begin n_fail++; $display("FAIL single_key_neg: got %b exp 0", key_active_neg); end
    n_checks++; if (key_code !== 6'h15) begin n_fail++; $display("FAIL single_code: got %0h exp 15", key_code); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL single_state_press: got %0h exp 1", state); end
    measure(1'b0, ht, hc, gt, gc, bad, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b exp 0", tmo); end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL single_consistency: got %b exp 0", bad); end
    n_checks++; if (ht !== HOLD) begin n_fail++; $display("FAIL single_hold_ticks: got %0d exp %0d", ht, HOLD); end
    n_checks++; if (gt !== GAP) begin n_fail++; $display("FAIL single_gap_ticks: got %0d exp %0d", gt, GAP); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b exp 0", busy); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL single_state_done: got %0h exp 0", state); end
    n_checks++; if (key_code !== 6'h15) begin n_fail++; $display("FAIL single_code_held: got %0h exp 15", key_code); end
    wait_edge(tk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b exp 0", done); end
  endtask

  task automatic test_debounce();
    logic tk;
    int r0, f0, ht, hc, gt, gc;
    bit bad, tmo;
    r0 = db_rises; f0 = db_falls;
    req = 1'b1; code = 6'h0A;
    wait_edge(tk);
    req = 1'b0;
    measure(1'b0, ht, hc, gt, gc, bad, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL debounce_timeout: got %b exp 0", tmo); end
    n_checks++; if (db_rises - r0 !== 1) begin n_fail++; $display("FAIL debounce_rises: got %0d exp 1", db_rises - r0); end
    n_checks++; if (db_falls - f0 !== 1) begin n_fail++; $display("FAIL debounce_falls: got %0d exp 1", db_falls - f0); end
    wait_edge(tk);
  endtask

  task automatic test_back_to_back();
    logic tk;
    int r0, f0, ht, hc, gt, gc, extra;
    bit bad, tmo;
    r0 = db_rises; f0 = db_falls;
    req = 1'b1; code = 6'h01;
    wait_edge(tk);
    n_checks++; if (key_code !== 6'h01) begin n_fail++; $display("FAIL b2b_code1: got %0h exp 01", key_code); end
    code = 6'h02;
    measure(1'b0, ht, hc, gt, gc, bad, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout1: got %b exp 0", tmo); end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL b2b_consistency1: got %b exp 0", bad); end
    n_checks++; if (ht !== HOLD) begin n_fail++; $display("FAIL b2b_hold1: got %0d exp %0d", ht, HOLD); end
    n_checks++; if (gt !== GAP) begin n_fail++; $display("FAIL b2b_gap1: got %0d exp %0d", gt, GAP); end
    wait_edge(tk);
    req = 1'b0;
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL b2b_second_up: got %b exp 1", key_active); end
    n_checks++; if (key_code !== 6'h02) begin n_fail++; $display("FAIL b2b_code2: got %0h exp 02", key_code); end
    measure(1'b0, ht, hc, gt, gc, bad, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout2: got %b exp 0", tmo); end
    n_checks++; if (ht !== HOLD) begin n_fail++; $display("FAIL b2b_hold2: got %0d exp %0d", ht, HOLD); end
    extra = 0;
    repeat (30) begin
      wait_edge(tk);
      if (key_active !== 1'b0) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_no_extra: got %0d exp 0", extra); end
    n_checks++; if (db_rises - r0 !== 2) begin n_fail++; $display("FAIL b2b_db_rises: got %0d exp 2", db_rises - r0); end
    n_checks++; if (db_falls - f0 !== 2) begin n_fail++; $display("FAIL b2b_db_falls: got %0d exp 2", db_falls - f0); end
  endtask

  task automatic test_busy_ignore();
    logic tk;
    int ht, hc, gt, gc, extra;
    bit bad, tmo;
    req = 1'b1; code = 6'h2C;
    wait_edge(tk);
    req = 1'b0;
    measure(1'b1, ht, hc, gt, gc, bad, tmo);
    req = 1'b0; code = 6'h00;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ignore_timeout: got %b exp 0", tmo); end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL ignore_consistency: got %b exp 0", bad); end
    n_checks++; if (ht !== HOLD) begin n_fail++; $display("FAIL ignore_hold: got %0d exp %0d", ht, HOLD); end
    n_checks++; if (gt !== GAP) begin n_fail++; $display("FAIL ignore_gap: got %0d exp %0d", gt, GAP); end
    n_checks++; if (key_code !== 6'h2C) begin n_fail++; $display("FAIL ignore_code: got %0h exp 2c", key_code); end
    extra = 0;
    repeat (10) begin
      wait_edge(tk);
      if (key_active !== 1'b0 || busy !== 1'b0) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_queue: got %0d exp 0", extra); end
  endtask

  task automatic test_reset_mid_press();
    logic tk;
    int ticks, n, ht, hc, gt, gc;
    bit bad, tmo;
    req = 1'b1; code = 6'h33;
    wait_edge(tk);
    req = 1'b0;
    ticks = 0; n = 0;
    while (ticks < 2 && n < 100) begin
      wait_edge(tk);
      n++;
      if (tk) ticks++;
    end
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL rstmid_before: got %b exp 1", key_active); end
    reset = 1'b1;
    wait_edge(tk);
    reset = 1'b0;
    n_checks++; if (key_active !== 1'b0) begin n_fail++; $display("FAIL rstmid_key: got %b exp 0", key_active); end
    n_checks++; if (key_active_neg !== 1'b1) begin n_fail++; $display("FAIL rstmid_key_neg: got %b exp 1", key_active_neg); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL rstmid_state: got %0h exp 0", state); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b exp 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    n_checks++; if (key_code !== 6'h00) begin n_fail++; $display("FAIL rstmid_code: got %0h exp 0", key_code); end
    req = 1'b1; code = 6'h12;
    wait_edge(tk);
    req = 1'b0;
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_up: got %b exp 1", key_active); end
    n_checks++; if (key_code !== 6'h12) begin n_fail++; $display("FAIL rstmid_new_code: got %0h exp 12", key_code); end
    measure(1'b0, ht, hc, gt, gc, bad, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout: got %b exp 0", tmo); end
    n_checks++; if (ht !== HOLD) begin n_fail++; $display("FAIL rstmid_hold: got %0d exp %0d", ht, HOLD); end
    n_checks++; if (gt !== GAP) begin n_fail++; $display("FAIL rstmid_gap: got %0d exp %0d", gt, GAP); end
    wait_edge(tk);
  endtask

  task automatic test_tick_always();
    logic tk;
    int ht, hc, gt, gc;
    bit bad, tmo;
    tick_always = 1'b1;
    wait_edge(tk);
    req = 1'b1; code = 6'h07;
    wait_edge(tk);
    req = 1'b0;
    n_checks++; if (key_active !== 1'b1) begin n_fail++; $display("FAIL fast_up: got %b exp 1", key_active); end
    measure(1'b0, ht, hc, gt, gc, bad, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL fast_timeout: got %b exp 0", tmo); end
    n_checks++; if (hc !== 4) begin n_fail++; $display("FAIL fast_hold_cycles: got %0d exp 4", hc); end
    n_checks++; if (gc !== 4) begin n_fail++; $display("FAIL fast_gap_cycles: got %0d exp 4", gc); end
    n_checks++; if (hc + gc + 1 !== 9) begin n_fail++; $display("FAIL fast_done_cycle: got %0d exp 9", hc + gc + 1); end
    wait_edge(tk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fast_done_width: got %b exp 0", done); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL fast_idle: got %0h exp 0", state); end
    tick_always = 1'b0;
    repeat (3) wait_edge(tk);
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    code  = 6'h00;
    test_reset();
    test_single_press();
    test_debounce();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_press();
    test_tick_always();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
